// File: rtl/mips_load_store_unit.sv
// Load/store formatting stage between the execute stage and a big-endian, byte-addressed memory.
// One request in flight; misaligned or reserved requests are answered without a memory access.
module mips_load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt_old,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic        mem_wr_en,
  output logic        mem_read_en,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] OpLb  = 4'd0;
  localparam logic [3:0] OpLbu = 4'd1;
  localparam logic [3:0] OpLh  = 4'd2;
  localparam logic [3:0] OpLhu = 4'd3;
  localparam logic [3:0] OpLw  = 4'd4;
  localparam logic [3:0] OpLwl = 4'd5;
  localparam logic [3:0] OpLwr = 4'd6;
  localparam logic [3:0] OpSb  = 4'd8;
  localparam logic [3:0] OpSh  = 4'd9;
  localparam logic [3:0] OpSw  = 4'd10;
  localparam logic [31:0] AllOnes = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] rt_old_q, rt_old_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_error_q, resp_error_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic        mem_wr_en_q, mem_wr_en_d;
  logic        mem_read_en_q, mem_read_en_d;
  logic [3:0]  mem_byte_en_q, mem_byte_en_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic [1:0]  req_k;
  logic        req_err;
  logic        req_is_store;
  logic [4:0]  lsh, rsh;
  logic [7:0]  lane;
  logic [15:0] half;
  logic [31:0] load_result;

  assign req_k        = req_addr[1:0];
  assign req_is_store = (req_op == OpSb) || (req_op == OpSh) || (req_op == OpSw);

  always_comb begin
    req_err = 1'b1;
    case (req_op)
      OpLb, OpLbu, OpLwl, OpLwr, OpSb: req_err = 1'b0;
      OpLh, OpLhu, OpSh:               req_err = req_k[0];
      OpLw, OpSw:                      req_err = |req_k;
      default:                         req_err = 1'b1;
    endcase
  end

  // Lane k sits at bit offset 8*(3-k) in the big-endian word.
  assign lsh  = {k_q, 3'b000};
  assign rsh  = {~k_q, 3'b000};
  assign lane = mem_rdata[rsh +: 8];
  assign half = k_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];

  always_comb begin
    load_result = 32'h0;
    case (op_q)
      OpLb:    load_result = {{24{lane[7]}}, lane};
      OpLbu:   load_result = {24'h0, lane};
      OpLh:    load_result = {{16{half[15]}}, half};
      OpLhu:   load_result = {16'h0, half};
      OpLw:    load_result = mem_rdata;
      OpLwl:   load_result = (mem_rdata << lsh) | (rt_old_q & ~(AllOnes << lsh));
      OpLwr:   load_result = (mem_rdata >> rsh) | (rt_old_q & ~(AllOnes >> rsh));
      default: load_result = 32'h0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    k_d           = k_q;
    rt_old_d      = rt_old_q;
    resp_data_d   = resp_data_q;
    resp_error_d  = resp_error_q;
    mem_address_d = mem_address_q;
    mem_byte_en_d = mem_byte_en_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wr_en_d   = 1'b0;
    mem_read_en_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d        = req_op;
          k_d         = req_k;
          rt_old_d    = req_rt_old;
          resp_data_d = 32'h0;
          if (req_err) begin
            resp_error_d = 1'b1;
            state_d      = StResp;
          end else begin
            resp_error_d  = 1'b0;
            state_d       = StIssue;
            mem_address_d = {req_addr[31:2], 2'b00};
            mem_wr_en_d   = req_is_store;
            mem_read_en_d = ~req_is_store;
            mem_byte_en_d = 4'b1111;
            mem_wdata_d   = 32'h0;
            case (req_op)
              OpSb: begin
                mem_byte_en_d = 4'b1000 >> req_k;
                mem_wdata_d   = {4{req_wdata[7:0]}};
              end
              OpSh: begin
                mem_byte_en_d = req_k[1] ? 4'b0011 : 4'b1100;
                mem_wdata_d   = {2{req_wdata[15:0]}};
              end
              OpSw:    mem_wdata_d = req_wdata;
              default: mem_wdata_d = 32'h0;
            endcase
          end
        end
      end
      // Only legal opcodes reach here, and bit 3 separates stores from loads.
      StIssue: state_d = op_q[3] ? StResp : StWait;
      StWait: begin
        resp_data_d = load_result;
        state_d     = StResp;
      end
      StResp: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      op_q          <= 4'h0;
      k_q           <= 2'h0;
      rt_old_q      <= 32'h0;
      resp_data_q   <= 32'h0;
      resp_error_q  <= 1'b0;
      mem_address_q <= 32'h0;
      mem_wr_en_q   <= 1'b0;
      mem_read_en_q <= 1'b0;
      mem_byte_en_q <= 4'h0;
      mem_wdata_q   <= 32'h0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      k_q           <= k_d;
      rt_old_q      <= rt_old_d;
      resp_data_q   <= resp_data_d;
      resp_error_q  <= resp_error_d;
      mem_address_q <= mem_address_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_read_en_q <= mem_read_en_d;
      mem_byte_en_q <= mem_byte_en_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign resp_valid  = (state_q == StResp);
  assign resp_data   = resp_data_q;
  assign resp_error  = resp_error_q;
  assign mem_address = mem_address_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_read_en = mem_read_en_q;
  assign mem_byte_en = mem_byte_en_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Bench for mips_load_store_unit: directed vector table, reset corner cases, then random traffic
// checked against a byte-array model of memory and the load/store rules.
module tb_mips_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_rt_old;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_error;
  logic [31:0] mem_address;
  logic        mem_wr_en;
  logic        mem_read_en;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256] = '{default: 8'h00};

  always #5 clk = ~clk;

  mips_load_store_unit dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_rt_old  (req_rt_old),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_error  (resp_error),
    .mem_address (mem_address),
    .mem_wr_en   (mem_wr_en),
    .mem_read_en (mem_read_en),
    .mem_byte_en (mem_byte_en),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Big-endian byte memory with a registered read port (low 256 bytes of the address space).
  always @(posedge clk) begin
    if (mem_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_byte_en[3-i]) mem[{mem_address[7:2], 2'(i)}] <= mem_wdata[31-8*i -: 8];
      end
    end
    if (mem_read_en) begin
      mem_rdata <= {mem[{mem_address[7:2], 2'd0}], mem[{mem_address[7:2], 2'd1}],
                    mem[{mem_address[7:2], 2'd2}], mem[{mem_address[7:2], 2'd3}]};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour: error rules, store byte placement, load extraction by bytes.
  task automatic ref_exec(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rt, output logic err, output logic [31:0] data,
                          output int lat, output logic [3:0] be);
    logic [7:0]  a, base;
    logic [31:0] word;
    int          k, n;
    a    = addr[7:0];
    k    = int'(addr[1:0]);
    base = {a[7:2], 2'b00};
    word = {ref_mem[base], ref_mem[base+8'd1], ref_mem[base+8'd2], ref_mem[base+8'd3]};
    case (op)
      4'd0, 4'd1, 4'd5, 4'd6, 4'd8: err = 1'b0;
      4'd2, 4'd3, 4'd9:             err = (k % 2) != 0;
      4'd4, 4'd10:                  err = k != 0;
      default:                      err = 1'b1;
    endcase
    data = 32'h0;
    be   = 4'h0;
    if (err) begin
      lat = 1;
    end else if (op >= 4'd8) begin
      lat = 2;
      n   = (op == 4'd8) ? 1 : (op == 4'd9) ? 2 : 4;
      for (int j = 0; j < n; j++) begin
        ref_mem[a + 8'(j)] = 8'(wd >> (8 * (n - 1 - j)));
        be[3-k-j] = 1'b1;
      end
    end else begin
      lat = 3;
      be  = 4'hF;
      case (op)
        4'd0, 4'd1: begin
          data = 32'(ref_mem[a]);
          if (op == 4'd0 && data >= 32'd128) data = data - 32'd256;
        end
        4'd2, 4'd3: begin
          data = 32'({ref_mem[a], ref_mem[a+8'd1]});
          if (op == 4'd2 && data >= 32'd32768) data = data - 32'd65536;
        end
        4'd4: data = word;
        4'd5: for (int j = 0; j < 4; j++)
                data[31-8*j -: 8] = (j <= 3 - k) ? ref_mem[base + 8'(k + j)] : rt[31-8*j -: 8];
        default: for (int j = 0; j < 4; j++)
                data[31-8*j -: 8] = (j >= 3 - k) ? ref_mem[base + 8'(j - (3 - k))]
                                                 : rt[31-8*j -: 8];
      endcase
    end
  endtask

  task automatic start_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rt);
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_op     = op;
    req_addr   = addr;
    req_wdata  = wd;
    req_rt_old = rt;
    @(posedge clk);
  endtask

  task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rt, output logic got_err, output logic [31:0] got_data,
                        output logic [3:0] got_be, output logic [31:0] got_wd);
    logic        e_err;
    logic [31:0] e_data, cap_ad, e_lanes, a_lanes;
    logic [3:0]  e_be;
    logic [7:0]  base;
    int          e_lat, lat, wr_n, rd_n;
    ref_exec(op, addr, wd, rt, e_err, e_data, e_lat, e_be);
    start_req(op, addr, wd, rt);
    lat = 0; wr_n = 0; rd_n = 0; got_be = 4'h0; got_wd = 32'h0; cap_ad = 32'h0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (mem_wr_en || mem_read_en) begin
        got_be = mem_byte_en;
        got_wd = mem_wdata;
        cap_ad = mem_address;
      end
      if (mem_wr_en) wr_n++;
      if (mem_read_en) rd_n++;
    end while (!resp_valid && lat < 10);
    got_err  = resp_error;
    got_data = resp_data;
    chk("latency", 32'(lat), 32'(e_lat));
    chk("resp_error", 32'(resp_error), 32'(e_err));
    chk("resp_data", resp_data, e_data);
    chk("wr_pulses", 32'(wr_n), (!e_err && op >= 4'd8) ? 32'd1 : 32'd0);
    chk("rd_pulses", 32'(rd_n), (!e_err && op < 4'd8) ? 32'd1 : 32'd0);
    chk("byte_en", 32'(got_be), 32'(e_be));
    chk("mem_address", cap_ad, e_err ? 32'h0 : {addr[31:2], 2'b00});
    if (!e_err && op >= 4'd8) begin
      base = {addr[7:2], 2'b00};
      e_lanes = 32'h0;
      a_lanes = 32'h0;
      for (int j = 0; j < 4; j++) begin
        if (e_be[3-j]) begin
          e_lanes[31-8*j -: 8] = ref_mem[base + 8'(j)];
          a_lanes[31-8*j -: 8] = got_wd[31-8*j -: 8];
        end
      end
      chk("store_lanes", a_lanes, e_lanes);
    end
    @(negedge clk);
    chk("resp_one_cycle", 32'(resp_valid), 32'd0);
    chk("ready_after_resp", 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rt;
    logic        err;
    logic [31:0] data;
    logic [3:0]  be;
    logic        chk_wd;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        g_err, m_err;
    logic [31:0] g_data, g_wd, m_data;
    logic [3:0]  g_be, m_be;
    logic [3:0]  r_op;
    logic [31:0] r_addr;
    int          m_lat, seen;

    vecs[0]  = '{4'd10, 32'h8, 32'h12345678, 32'h0,        1'b0, 32'h0,        4'b1111, 1'b1, 32'h12345678};
    vecs[1]  = '{4'd4,  32'h8, 32'h0,        32'h0,        1'b0, 32'h12345678, 4'b1111, 1'b0, 32'h0};
    vecs[2]  = '{4'd8,  32'h9, 32'h000000AB, 32'h0,        1'b0, 32'h0,        4'b0100, 1'b1, 32'hABABABAB};
    vecs[3]  = '{4'd0,  32'h9, 32'h0,        32'h0,        1'b0, 32'hFFFFFFAB, 4'b1111, 1'b0, 32'h0};
    vecs[4]  = '{4'd1,  32'h9, 32'h0,        32'h0,        1'b0, 32'h000000AB, 4'b1111, 1'b0, 32'h0};
    vecs[5]  = '{4'd9,  32'hA, 32'h00008001, 32'h0,        1'b0, 32'h0,        4'b0011, 1'b1, 32'h80018001};
    vecs[6]  = '{4'd2,  32'hA, 32'h0,        32'h0,        1'b0, 32'hFFFF8001, 4'b1111, 1'b0, 32'h0};
    vecs[7]  = '{4'd3,  32'hA, 32'h0,        32'h0,        1'b0, 32'h00008001, 4'b1111, 1'b0, 32'h0};
    vecs[8]  = '{4'd5,  32'h9, 32'h0,        32'hDEADBEEF, 1'b0, 32'hAB8001EF, 4'b1111, 1'b0, 32'h0};
    vecs[9]  = '{4'd6,  32'h9, 32'h0,        32'hDEADBEEF, 1'b0, 32'hDEAD12AB, 4'b1111, 1'b0, 32'h0};
    vecs[10] = '{4'd5,  32'h8, 32'h0,        32'hDEADBEEF, 1'b0, 32'h12AB8001, 4'b1111, 1'b0, 32'h0};
    vecs[11] = '{4'd6,  32'hB, 32'h0,        32'hDEADBEEF, 1'b0, 32'h12AB8001, 4'b1111, 1'b0, 32'h0};
    vecs[12] = '{4'd4,  32'h6, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 1'b0, 32'h0};
    vecs[13] = '{4'd9,  32'h9, 32'h5555,     32'h0,        1'b1, 32'h0,        4'b0000, 1'b0, 32'h0};
    vecs[14] = '{4'd7,  32'h8, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 1'b0, 32'h0};

    reset = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_addr = 32'h0;
    req_wdata = 32'h0; req_rt_old = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_error", 32'(resp_error), 32'd0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_byte_en", 32'(mem_byte_en), 32'd0);
    chk("rst_strobes", 32'({mem_wr_en, mem_read_en}), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      do_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rt, g_err, g_data, g_be, g_wd);
      chk($sformatf("vec%0d_err", i), 32'(g_err), 32'(vecs[i].err));
      chk($sformatf("vec%0d_data", i), g_data, vecs[i].data);
      chk($sformatf("vec%0d_be", i), 32'(g_be), 32'(vecs[i].be));
      if (vecs[i].chk_wd) chk($sformatf("vec%0d_wdata", i), g_wd, vecs[i].wd);
    end

    // Reset during WAIT: no response, FSM idle next cycle.
    ref_exec(4'd4, 32'h8, 32'h0, 32'h0, m_err, m_data, m_lat, m_be);
    start_req(4'd4, 32'h8, 32'h0, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstwait_ready", 32'(req_ready), 32'd1);
    chk("rstwait_strobes", 32'({mem_wr_en, mem_read_en}), 32'd0);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    chk("rstwait_no_resp", 32'(seen), 32'd0);
    do_req(4'd4, 32'h8, 32'h0, 32'h0, g_err, g_data, g_be, g_wd);
    chk("after_rstwait_lw", g_data, 32'h12AB8001);

    // Reset during ISSUE: the store still lands in memory.
    ref_exec(4'd10, 32'h10, 32'hCAFEF00D, 32'h0, m_err, m_data, m_lat, m_be);
    start_req(4'd10, 32'h10, 32'hCAFEF00D, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstissue_wr_high", 32'(mem_wr_en), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstissue_ready", 32'(req_ready), 32'd1);
    chk("rstissue_strobes", 32'({mem_wr_en, mem_read_en}), 32'd0);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    chk("rstissue_no_resp", 32'(seen), 32'd0);
    do_req(4'd4, 32'h10, 32'h0, 32'h0, g_err, g_data, g_be, g_wd);
    chk("after_rstissue_lw", g_data, 32'hCAFEF00D);

    // Random traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      r_op   = 4'($urandom_range(0, 15));
      r_addr = $urandom;
      if ($urandom_range(0, 1) == 0) r_addr[1:0] = 2'b00;
      do_req(r_op, r_addr, $urandom, $urandom, g_err, g_data, g_be, g_wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_load_store_unit.md
# mips_load_store_unit

Load/store formatting stage between the CPU execute stage and the byte-addressed, big-endian `mips_memory`. It accepts one load or store request at a time and drives the memory's word-aligned address, read/write strobes, byte enables and replicated write data. For loads, it sign- or zero-extends the returned lane, or merges it for LWL/LWR, then returns a one-cycle response. Misaligned accesses and reserved opcodes are rejected without touching memory.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  high only in IDLE; request accepted at an edge where `req_valid && req_ready`
- `req_op`  in  4  operation code:
  - 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR
  - 8 SB, 9 SH, 10 SW
  - all other codes reserved
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data (rt)
- `req_rt_old`  in  32  current rt value, used by LWL/LWR merge
- `resp_valid`  out  1  one-cycle response pulse; no back-pressure
- `resp_data`  out  32  load result; 0 for stores and errors
- `resp_error`  out  1  address/opcode error, valid with `resp_valid`
- `mem_address`  out  32  `{req_addr[31:2],2'b00}`
- `mem_wr_en`  out  1  to memory `wr_en`
- `mem_read_en`  out  1  to memory `read_en`
- `mem_byte_en`  out  4  to memory `byte_en`; bit 3 = address+0 = bits [31:24]
- `mem_wdata`  out  32  to memory `data_in`
- `mem_rdata`  in  32  from memory `data_out`; valid the cycle after the `read_en` edge

## Operation
- Let k = `req_addr[1:0]`. Big-endian lane k is bits [31-8k -: 8] and maps to `byte_en` bit 3-k.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE: `req_ready`=1. On accept, the next state depends on the request:
  - Error, i.e. reserved op, LH/LHU/SH with k[0]=1, or LW/SW with k≠0: go to RESP with `resp_error`=1, `resp_data`=0, no strobes.
  - Otherwise: go to ISSUE with the mem_* registers loaded.
- ISSUE: strobes are high for exactly this one cycle. Next state is RESP for a store, WAIT for a load.
- WAIT: format `mem_rdata` into the result register, then go to RESP.
- RESP: `resp_valid`=1, then return to IDLE.
- Store encoding:
  - SB: `byte_en` = 4'b1000>>k, `wdata` = `{4{wdata[7:0]}}`.
  - SH: `byte_en` = 1100 (k=0) or 0011 (k=2), `wdata` = `{2{wdata[15:0]}}`.
  - SW: `byte_en` = 1111.
- Loads: `mem_read_en`=1, `byte_en`=1111, `wr_en`=0.
- Load formatting:
  - LB/LBU: sign- or zero-extend lane k.
  - LH/LHU: extend bits [31:16] when k=0, bits [15:0] when k=2.
  - LW: full word.
  - LWL: `(word << 8k) | (rt_old & ((1<<8k)-1))`.
  - LWR: `(word >> 8(3-k)) | (rt_old & ~(32'hFFFFFFFF >> 8(3-k)))`.

## Timing
- Let T0 be the accept edge. `resp_valid` is high in the cycle after:
  - T0+1 edge for errors (1 cycle)
  - T0+2 edge for stores (2 cycles)
  - T0+3 edge for loads (3 cycles)
- Memory samples the strobes at edge T0+1. For loads, `mem_rdata` is sampled at edge T0+2.
- Throughput: one request per 2/3/4 cycles (error/store/load). `req_ready`=0 in ISSUE, WAIT and RESP.
- Reset values: state IDLE, `req_ready`=1, and every other output 0, including `mem_address`, `mem_wdata` and `mem_byte_en`.
- Reset mid-operation:
  - The FSM returns to IDLE at the reset edge and no response is issued.
  - If reset is asserted during ISSUE, memory still samples the strobes at that same edge, so the write or read completes. Strobes are 0 from the following cycle.
- `resp_data`/`resp_error` hold their value only while `resp_valid`=1. They are don't-care otherwise.

## Test plan
- SW addr 0x8, wdata 0x12345678 -> `byte_en` 1111, `wr_en` high for one cycle, `resp_valid` 2 cycles after accept, `resp_error` 0. Then LW 0x8 -> `resp_data` 0x12345678, 3 cycles after accept.
- SB addr 0x9, wdata 0x000000AB -> `byte_en` 0100, `mem_wdata` 0xABABABAB. Then LB 0x9 -> 0xFFFFFFAB; LBU 0x9 -> 0x000000AB.
- SH addr 0xA, wdata 0x8001 -> `byte_en` 0011, `mem_address` 0x8. Then LH 0xA -> 0xFFFF8001; LHU 0xA -> 0x00008001.
- Word at 0x8 is now 0x12AB8001, `rt_old` = 0xDEADBEEF:
  - LWL 0x9 -> 0xAB8001EF.
  - LWR 0x9 -> 0xDEAD12AB.
  - LWL 0x8 -> 0x12AB8001.
  - LWR 0xB -> 0x12AB8001.
- LW 0x6, SH 0x9 and op 7 -> each gives `resp_error` 1, `resp_data` 0, `resp_valid` 1 cycle after accept, and no `wr_en`/`read_en` pulse.
- Reset asserted for one cycle while in WAIT -> next cycle IDLE, `req_ready` 1, no `resp_valid` pulse. A following LW 0x8 returns 0x12AB8001 normally.
